// File: rtl/dig_pin_filter_mc.sv
// Multi-channel pin filter: per-channel 1..3 stage synchronizer followed by a
// debounce counter that emits a clean level plus rise/fall/glitch pulses.
module dig_pin_filter_mc #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NUM_CH-1:0] pin_i,
    input  logic [NUM_CH-1:0] en_i,
    input  logic [1:0]        sync_sel_i,
    input  logic [CNT_W-1:0]  filt_len_i,
    input  logic [1:0]        filt_mode_i,
    output logic [NUM_CH-1:0] pin_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] glitch_o,
    output logic [NUM_CH-1:0] busy_o
);

    typedef enum logic {
        StIdle,
        StCount
    } state_e;

    logic [CNT_W-1:0] filt_len_eff;
    logic             rise_unfilt;
    logic             fall_unfilt;

    assign filt_len_eff = (filt_len_i == '0) ? CNT_W'(1) : filt_len_i;

    // Mode 1 filters only rising edges, so falling ones pass straight through (and vice versa).
    assign rise_unfilt = (filt_mode_i == 2'd3) || (filt_mode_i == 2'd2);
    assign fall_unfilt = (filt_mode_i == 2'd3) || (filt_mode_i == 2'd1);

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        logic [2:0]       sync_q;
        logic             samp;
        logic             unfilt;
        logic             take;
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
        logic             pin_q, pin_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;
        logic             glitch_q, glitch_d;

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[1:0], pin_i[g]};
            end
        end

        always_comb begin
            samp = sync_q[0];
            case (sync_sel_i)
                2'd3:    samp = sync_q[2];
                2'd2:    samp = sync_q[1];
                default: samp = sync_q[0];
            endcase
        end

        assign unfilt  = samp ? rise_unfilt : fall_unfilt;
        assign cnt_inc = cnt_q + CNT_W'(1);

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            pin_d    = pin_q;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            glitch_d = 1'b0;
            take     = 1'b0;

            if (!en_i[g]) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (samp != pin_q) begin
                            if (unfilt || (filt_len_eff <= CNT_W'(1))) begin
                                take = 1'b1;
                            end else begin
                                cnt_d   = CNT_W'(1);
                                state_d = StCount;
                            end
                        end
                    end
                    StCount: begin
                        if (samp == pin_q) begin
                            glitch_d = 1'b1;
                            cnt_d    = '0;
                            state_d  = StIdle;
                        end else if (unfilt || (cnt_inc >= filt_len_eff)) begin
                            // Live length/mode: a lowered length or newly unfiltered
                            // direction completes the pending transition at once.
                            take    = 1'b1;
                            cnt_d   = '0;
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                endcase
            end

            if (take) begin
                pin_d  = samp;
                rise_d = samp;
                fall_d = ~samp;
            end
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                state_q  <= StIdle;
                cnt_q    <= '0;
                pin_q    <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                glitch_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                pin_q    <= pin_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                glitch_q <= glitch_d;
            end
        end

        assign pin_o[g]    = pin_q;
        assign rise_o[g]   = rise_q;
        assign fall_o[g]   = fall_q;
        assign glitch_o[g] = glitch_q;
        assign busy_o[g]   = (state_q == StCount);
    end

endmodule

// File: tb/tb_dig_pin_filter_mc.sv
// Scoreboard bench for dig_pin_filter_mc: stimulus queues expected pulse events
// (channel, kind, cycle); a negedge monitor pops and compares each observed pulse.
module tb_dig_pin_filter_mc;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic [3:0] pin_i;
    logic [3:0] en_i;
    logic [1:0] sync_sel_i;
    logic [7:0] filt_len_i;
    logic [1:0] filt_mode_i;
    logic [3:0] pin_o;
    logic [3:0] rise_o;
    logic [3:0] fall_o;
    logic [3:0] glitch_o;
    logic [3:0] busy_o;

    dig_pin_filter_mc #(
        .NUM_CH(4),
        .CNT_W (8)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .pin_i      (pin_i),
        .en_i       (en_i),
        .sync_sel_i (sync_sel_i),
        .filt_len_i (filt_len_i),
        .filt_mode_i(filt_mode_i),
        .pin_o      (pin_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .glitch_o   (glitch_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // kind: 0 rise, 1 fall, 2 glitch
    typedef struct {
        int ch;
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
        end
    endtask

    task automatic push(input int ch, input int kind, input int c);
        ev_t e;
        e.ch   = ch;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    always @(negedge clk_i) begin : mon
        logic [2:0] pv;
        ev_t        e;
        for (int ch = 0; ch < 4; ch++) begin
            pv = {glitch_o[ch], fall_o[ch], rise_o[ch]};
            for (int k = 0; k < 3; k++) begin
                if (pv[k]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_event ch=%0d kind=%0d cyc=%0d actual=pulse required=none",
                                 ch, k, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ev_ch", ch, e.ch);
                        chk("ev_kind", k, e.kind);
                        chk("ev_cyc", cyc, e.cyc);
                        if (k < 2) chk("ev_level", int'(pin_o[ch]), (k == 0) ? 1 : 0);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        rstn_i      = 1'b0;
        pin_i       = 4'hF;
        en_i        = 4'hF;
        sync_sel_i  = 2'd2;
        filt_len_i  = 8'd4;
        filt_mode_i = 2'd0;
        step(3);
        chk("rst_pin", pin_o, 0);
        chk("rst_rise", rise_o, 0);
        chk("rst_fall", fall_o, 0);
        chk("rst_glitch", glitch_o, 0);
        chk("rst_busy", busy_o, 0);

        // Rising on all channels: N=2, L=4
        rstn_i = 1'b1;
        c      = cyc;
        for (int ch = 0; ch < 4; ch++) push(ch, 0, c + 6);
        for (int k = 1; k <= 7; k++) begin
            step(1);
            chk("t1_busy", busy_o, (k >= 3 && k <= 5) ? 15 : 0);
        end
        chk("t1_pin", pin_o, 15);
        step(4);

        pin_i = 4'h0;
        c     = cyc;
        for (int ch = 0; ch < 4; ch++) push(ch, 1, c + 6);
        step(10);
        chk("fall_all_pin", pin_o, 0);

        // 3-cycle pulse on ch0 with L=5 -> one glitch
        filt_len_i = 8'd5;
        pin_i      = 4'b0001;
        c          = cyc;
        push(0, 2, c + 6);
        step(3);
        pin_i = 4'h0;
        step(10);
        chk("t2_pin", pin_o, 0);

        filt_len_i = 8'd4;
        pin_i      = 4'hF;
        c          = cyc;
        for (int ch = 0; ch < 4; ch++) push(ch, 0, c + 6);
        step(10);
        chk("t3_setup_pin", pin_o, 15);

        // Mode 1: falling is unfiltered, passes after N edges
        filt_mode_i = 2'd1;
        filt_len_i  = 8'd10;
        pin_i       = 4'b1101;
        c           = cyc;
        push(1, 1, c + 3);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("t3_busy", busy_o, 0);
        end
        chk("t3_pin", pin_o, 4'b1101);

        // Long count, then shorten the length mid-count
        filt_mode_i = 2'd0;
        filt_len_i  = 8'd200;
        pin_i       = 4'b0101;
        c           = cyc;
        step(52);
        chk("t4_busy", busy_o, 8);
        chk("t4_pin_hold", pin_o, 4'b1101);
        filt_len_i = 8'd3;
        push(3, 1, c + 53);
        step(1);
        chk("t4_pin", pin_o, 4'b0101);
        step(5);

        // Disabled channel holds its level
        filt_len_i = 8'd4;
        en_i       = 4'b1011;
        pin_i      = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            chk("t5_hold", int'(pin_o[2]), 1);
            chk("t5_busy", int'(busy_o[2]), 0);
        end
        en_i = 4'hF;
        c    = cyc;
        push(2, 1, c + 4);
        step(6);
        chk("t5_pin", pin_o, 4'b0001);

        // Boundaries: sel 0 / len 0 act as 1; then 3-stage sync, len 1
        sync_sel_i = 2'd0;
        filt_len_i = 8'd0;
        pin_i      = 4'b0000;
        c          = cyc;
        push(0, 1, c + 2);
        step(4);
        sync_sel_i = 2'd3;
        filt_len_i = 8'd1;
        pin_i      = 4'b0001;
        c          = cyc;
        push(0, 0, c + 4);
        step(6);
        chk("bnd_pin", pin_o, 4'b0001);

        // Reset mid-count, then full latency again
        sync_sel_i = 2'd2;
        filt_len_i = 8'd4;
        pin_i      = 4'hF;
        step(5);
        chk("t6_busy", busy_o, 4'b1110);
        rstn_i = 1'b0;
        #1;
        chk("t6_rst_pin", pin_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_pulses", {rise_o, fall_o, glitch_o}, 0);
        step(2);
        rstn_i = 1'b1;
        c      = cyc;
        for (int ch = 0; ch < 4; ch++) push(ch, 0, c + 6);
        step(5);
        chk("t6_pin_pre", pin_o, 0);
        step(1);
        chk("t6_pin", pin_o, 15);
        step(5);

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
